// File: rtl/amds_link_pkg.sv
// Constants and helpers shared by both ends of the AMDS->AMDC serial link.
// The transmit sequencer state type lives here so checkers can bind to it.
package amds_link_pkg;

  localparam logic [3:0] HEADER_NIBBLE    = 4'h9;
  localparam int         NUM_PACKETS      = 4;
  localparam int         BYTES_PER_PACKET = 3;
  localparam int         FRAME_BITS       = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic calc_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/amds_uart_tx_byte.sv
// Single UART byte serializer: start, 8 data bits LSB first, parity, stop.
// A start pulse in the last stop-bit cycle chains the next frame with no idle bit.
module uart_tx_byte
  import amds_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       par_inv,
  output logic       dout,
  output logic       done
);

  localparam int              TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]      B_LAST = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg;
  logic [TW-1:0]         timer;
  logic [3:0]            bit_cnt;
  logic                  active;

  // done is asserted during the final cycle of the stop bit
  assign done = active && (bit_cnt == B_LAST) && (timer == T_LAST);
  assign dout = shreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '1;
      timer   <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
    end else if (start) begin
      shreg   <= {1'b1, calc_parity(data) ^ par_inv, data, 1'b0};
      timer   <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (timer == T_LAST) begin
        timer <= '0;
        // shifting in ones leaves the line idle-high once the stop bit is out
        shreg <= {1'b1, shreg[FRAME_BITS-1:1]};
        if (bit_cnt == B_LAST) begin
          active <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/amds_uart_tx.sv
// Packet sequencer for the AMDS ADC link: sends four samples as twelve framed bytes
// (header 0x90+n, MSB, LSB) per trigger, with optional inter-byte gap and parity faults.
module amds_uart_tx
  import amds_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int GAP_CLKS     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_tx,
  input  logic [15:0]     din0,
  input  logic [15:0]     din1,
  input  logic [15:0]     din2,
  input  logic [15:0]     din3,
  input  logic [3:0]      inject_parity_err,
  output logic            dout,
  output logic            busy,
  output logic            tx_done,
  output logic [15:0]     counter_tx_done,
  output tx_state_e       state_dbg
);

  localparam int            GW       = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
  localparam logic [3:0]    LAST_IDX = 4'(NUM_PACKETS * BYTES_PER_PACKET - 1);

  tx_state_e    state;
  logic [3:0]   idx;
  logic [3:0]   next_idx;
  logic [GW-1:0] gap_cnt;
  logic [15:0]  samples [NUM_PACKETS];
  logic [3:0]   inj_q;

  logic         byte_start;
  logic [7:0]   byte_data;
  logic         par_inv;
  logic         ser_done;
  logic [1:0]   pkt;
  logic [1:0]   slot;

  assign state_dbg = state;

  // Handshake: start_tx is a single-cycle request, taken only when busy is low;
  // there is no ready output and requests while busy are dropped.

  // The next byte is issued combinationally so the serializer reloads on the
  // same edge its previous stop bit ends (or the gap expires).
  always_comb begin
    byte_start = 1'b0;
    next_idx   = idx + 4'd1;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        byte_start = start_tx;
        next_idx   = 4'd0;
      end
      ST_SEND: byte_start = ser_done && (idx != LAST_IDX) && (GAP_CLKS == 0);
      ST_GAP:  byte_start = (gap_cnt == GAP_LAST);
      default: byte_start = 1'b0;
    endcase
  end

  always_comb begin
    pkt       = 2'(next_idx / 4'd3);
    slot      = 2'(next_idx % 4'd3);
    byte_data = 8'h00;
    unique case (slot)
      2'd0:    byte_data = {HEADER_NIBBLE, 2'b00, pkt};
      2'd1:    byte_data = samples[pkt][15:8];
      default: byte_data = samples[pkt][7:0];
    endcase
    par_inv = (slot == 2'd1) && inj_q[pkt];
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk     (clk),
    .rst     (rst),
    .start   (byte_start),
    .data    (byte_data),
    .par_inv (par_inv),
    .dout    (dout),
    .done    (ser_done)
  );

  // LOAD is the first cycle of each frame; the serializer is already driving its start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      idx             <= '0;
      gap_cnt         <= '0;
      busy            <= 1'b0;
      tx_done         <= 1'b0;
      counter_tx_done <= '0;
      inj_q           <= '0;
      for (int i = 0; i < NUM_PACKETS; i++) samples[i] <= '0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_tx) begin
            samples[0] <= din0;
            samples[1] <= din1;
            samples[2] <= din2;
            samples[3] <= din3;
            inj_q      <= inject_parity_err;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LOAD: state <= ST_SEND;
        ST_SEND: begin
          if (ser_done) begin
            if (idx == LAST_IDX) begin
              state           <= ST_DONE;
              tx_done         <= 1'b1;
              busy            <= 1'b0;
              counter_tx_done <= counter_tx_done + 16'd1;
            end else if (GAP_CLKS > 0) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              idx   <= next_idx;
              state <= ST_LOAD;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            idx   <= next_idx;
            state <= ST_LOAD;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_amds_uart_tx.sv
// Bench for amds_uart_tx: two instances (no gap, 3-cycle gap) checked against a
// frame-level model of the expected byte stream and its timing.
module tb_amds_uart_tx;
  import amds_link_pkg::*;

  localparam int CPB  = 4;
  localparam int GAP0 = 0;
  localparam int GAP1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [2];
  logic [15:0] din0, din1, din2, din3;
  logic [3:0]  inject;
  logic        dout_w [2];
  logic        busy_w [2];
  logic        tx_done_w [2];
  logic [15:0] counter_w [2];
  tx_state_e   st_w [2];

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_cnt [2];
  logic        wave [0:699];
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  amds_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP0)) dut0 (
    .clk(clk), .rst(rst), .start_tx(start_v[0]),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .inject_parity_err(inject),
    .dout(dout_w[0]), .busy(busy_w[0]), .tx_done(tx_done_w[0]),
    .counter_tx_done(counter_w[0]), .state_dbg(st_w[0])
  );

  amds_uart_tx #(.CLKS_PER_BIT(CPB), .GAP_CLKS(GAP1)) dut1 (
    .clk(clk), .rst(rst), .start_tx(start_v[1]),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .inject_parity_err(inject),
    .dout(dout_w[1]), .busy(busy_w[1]), .tx_done(tx_done_w[1]),
    .counter_tx_done(counter_w[1]), .state_dbg(st_w[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transmission on DUT `which`; abort_at>0 pulses rst in that cycle instead.
  task automatic run_tx(input int which, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3, input logic [3:0] inj,
                        input bit mid_start, input bit chain, input int abort_at);
    logic [15:0] d [4];
    logic [7:0]  b;
    logic [10:0] got;
    int gap, exp_done, done_at, pos, bad, gh;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    gap = (which == 0) ? GAP0 : GAP1;
    exp_done = 12 * 11 * CPB + 11 * gap + 1;
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      for (int s = 0; s < 3; s++) begin
        b = (s == 0) ? 8'(8'h90 + n) : (s == 1) ? d[n][15:8] : d[n][7:0];
        exp_q.push_back({1'b1, (^b) ^ ((s == 1) && inj[n]), b, 1'b0});
      end
    end
    if (!chain) repeat (3) @(negedge clk);
    din0 = d0; din1 = d1; din2 = d2; din3 = d3; inject = inj;
    start_v[which] = 1'b1;
    done_at = 0;
    for (int k = 1; k <= exp_done + 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_v[which] = 1'b0;
        din0 = 16'($urandom);
        inject = 4'($urandom);
        check($sformatf("busy_up%0d", which), 32'(busy_w[which]), 32'd1);
      end
      if (mid_start && k == 200) start_v[which] = 1'b1;
      if (mid_start && k == 201) start_v[which] = 1'b0;
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_dout", 32'(dout_w[which]), 32'd1);
        check("rst_busy", 32'(busy_w[which]), 32'd0);
        check("rst_count", 32'(counter_w[which]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt[0] = '0;
        exp_cnt[1] = '0;
        return;
      end
      wave[k] = dout_w[which];
      if (tx_done_w[which]) begin
        done_at = k;
        break;
      end
    end
    exp_cnt[which] = exp_cnt[which] + 16'd1;
    check($sformatf("done_cycle%0d", which), 32'(done_at), 32'(exp_done));
    check($sformatf("busy_low%0d", which), 32'(busy_w[which]), 32'd0);
    check($sformatf("count%0d", which), 32'(counter_w[which]), 32'(exp_cnt[which]));
    pos = 1;
    for (int by = 0; by < 12; by++) begin
      if (by > 0 && gap > 0) begin
        gh = 0;
        for (int g = 0; g < gap; g++) gh += int'(wave[pos + g]);
        check($sformatf("gap_high%0d_b%0d", which, by), 32'(gh), 32'(gap));
        pos += gap;
      end
      got = '0;
      bad = 0;
      for (int i = 0; i < 11; i++) begin
        got[i] = wave[pos + i * CPB];
        for (int c = 1; c < CPB; c++) if (wave[pos + i * CPB + c] !== got[i]) bad++;
      end
      check($sformatf("frame%0d_b%0d", which, by), 32'(got), 32'(exp_q.pop_front()));
      check($sformatf("stable%0d_b%0d", which, by), 32'(bad), 32'd0);
      pos += 11 * CPB;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0; inject = '0;
    exp_cnt[0] = '0; exp_cnt[1] = '0;
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      check($sformatf("reset_dout%0d", w), 32'(dout_w[w]), 32'd1);
      check($sformatf("reset_busy%0d", w), 32'(busy_w[w]), 32'd0);
      check($sformatf("reset_done%0d", w), 32'(tx_done_w[w]), 32'd0);
      check($sformatf("reset_count%0d", w), 32'(counter_w[w]), 32'd0);
    end
    rst = 1'b0;

    run_tx(0, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 4'b0000, 1'b0, 1'b0, 0);
    run_tx(1, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 4'b0000, 1'b0, 1'b0, 0);
    run_tx(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0100, 1'b0, 1'b0, 0);
    run_tx(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0000, 1'b1, 1'b0, 0);
    run_tx(1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b1001, 1'b1, 1'b0, 0);
    run_tx(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0010, 1'b0, 1'b1, 0);
    run_tx(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0000, 1'b0, 1'b1, 0);
    run_tx(1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0000, 1'b0, 1'b0, 150);
    check("rst_count_other", 32'(counter_w[0]), 32'd0);
    run_tx(1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 4'b0000, 1'b0, 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      run_tx(r % 2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/amds_uart_tx.md
Name: amds_uart_tx

Overview:
- Transmit end of the AMDS→AMDC ADC serial link.
- On each conversion trigger, serializes four 16-bit ADC samples as four 3-byte packets over one UART data line: header, data MSB, data LSB.
- Sits on the AMDS-side fabric between the ADC capture logic and the output pin.
- Produces the exact framing the AMDC receiver validates, and can inject parity faults for link testing.

Parameters:
- CLKS_PER_BIT, 8: clk cycles per UART bit; legal range ≥2.
- GAP_CLKS, 0: idle-high clk cycles inserted between consecutive bytes; 0 means back-to-back frames.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_tx  in  1  one-cycle request to send all four samples
- din0  in  16  sample for packet 0
- din1  in  16  sample for packet 1
- din2  in  16  sample for packet 2
- din3  in  16  sample for packet 3
- inject_parity_err  in  4  bit n set at start_tx: invert parity of packet n MSB byte
- dout  out  1  serial line, idle high
- busy  out  1  high while a transmission is in progress
- tx_done  out  1  one-cycle pulse at end of the final stop bit
- counter_tx_done  out  16  count of completed transmissions, wraps at 0xFFFF→0

Behaviour:
- Reset values (asynchronous on rst, held while rst high): dout=1, busy=0, tx_done=0, counter_tx_done=0, state=IDLE; any in-flight frame is abandoned.
- start_tx is accepted only in IDLE. Accepting it latches din0..din3 and inject_parity_err into internal registers and sets busy the next cycle.
- start_tx while busy is ignored: no queueing, no effect on the current transmission.
- Byte frame, 11 bits, each bit held CLKS_PER_BIT cycles:
  - start bit 0
  - data bits 0..7, LSB first
  - parity bit = XOR of the 8 data bits (even parity), inverted when injection applies
  - stop bit 1
- Byte order, for packet n = 0..3:
  - header = {4'h9, 2'b00, n[1:0]}
  - data MSB = dinN[15:8]
  - data LSB = dinN[7:0]
- Totals: 12 bytes per transmission, header of packet n always 0x90+n.
- Latency: start_tx in cycle 0 → dout drives the first start bit from cycle 1.
- GAP_CLKS idle-high cycles separate consecutive bytes. No gap before the first byte or after the last.
- The final stop bit ends at cycle 12*11*CLKS_PER_BIT + 11*GAP_CLKS. In the next cycle:
  - tx_done pulses
  - busy falls
  - counter_tx_done increments
  - state returns to IDLE
- A start_tx in the cycle busy is low is accepted.
- FSM states:
  - IDLE: wait for start_tx; latch inputs; clear byte index.
  - LOAD: select the next byte from the byte index (0..11); issue a byte-start to the serializer.
  - SEND: wait for serializer done; if index==11 go DONE; else if GAP_CLKS>0 go GAP; else go LOAD.
  - GAP: count GAP_CLKS cycles, increment index, go LOAD.
  - DONE: pulse tx_done, increment counter, go IDLE.
- LOAD→start-bit handoff must add no extra idle cycle. When GAP_CLKS=0, frames are contiguous: a stop bit is immediately followed by the next start bit.
- Byte index counter is 4 bits; packet number = index/3, byte slot = index%3.
- Bit timer width is $clog2(CLKS_PER_BIT); gap counter width is $clog2(GAP_CLKS+1).

Decomposition:
- Shared package amds_link_pkg holds constants used by both link ends:
  - HEADER_NIBBLE=4'h9
  - NUM_PACKETS=4
  - BYTES_PER_PACKET=3
  - FRAME_BITS=11
  - parity function
- One sub-module, uart_tx_byte. It takes the 8-bit byte, a parity-invert flag and a start pulse; it outputs the serial bit and a done pulse. It owns the bit timer and the 11-bit shift register.
- The top level owns the packet sequencer, gap timer, input latches and counter.

Test Plan:
- CLKS_PER_BIT=4, GAP_CLKS=0; start_tx with din0=0x1234, din1=0xABCD, din2=0x0000, din3=0xFFFF → bench UART decode yields bytes 90 12 34 91 AB CD 92 00 00 93 FF FF, all even-parity correct. tx_done pulses at cycle 529; counter_tx_done=1.
- Same setup, check the first frame sample-by-sample: dout low for cycles 1–4, data bits 0,0,0,0,1,0,0,1, parity 0, stop 1 → 44 cycles exactly.
- GAP_CLKS=3 → dout stays high for exactly 3 cycles between every pair of stop/start bits. tx_done lands at cycle 562.
- inject_parity_err=4'b0100 → only the packet 2 MSB byte has an inverted parity bit; all other 11 bytes are correct.
- start_tx pulsed again mid-transmission, and din0 changed after acceptance → output is unchanged from the single-transmission case, counter increments by 1 only. A start_tx in the cycle after tx_done begins a second transmission.
- rst asserted mid-byte during packet 1 → dout=1, busy=0 immediately (asynchronous), counter=0. After release, a new start_tx sends a full, correct 12-byte sequence.
